conv_engine: RTL and testbench

CONV_ENGINE -- requirements
Module: conv_engine

---
 rtl/conv_engine_if.sv | 28 ++
 rtl/conv_engine.sv | 133 +++++++++++++
 tb/tb_conv_engine.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_engine_if.sv
// Window/kernel handshake and result bus shared by conv_engine and its producer/consumer.
// Widths follow the engine parameters; TAPS = K*K.
interface conv_engine_if #(
  parameter int PIX_W = 8,
  parameter int KER_W = 9,
  parameter int K     = 3,
  parameter int OUT_W = 8
);
  localparam int TAPS = K * K;

  logic                    in_valid;
  logic                    in_ready;
  logic [TAPS*PIX_W-1:0]   pixel_flat;
  logic [TAPS*KER_W-1:0]   kernel_flat;
  logic                    data_rdy;
  logic [OUT_W-1:0]        data_out;
  logic                    sat;

  modport master (
    output in_valid, pixel_flat, kernel_flat,
    input  in_ready, data_rdy, data_out, sat
  );

  modport slave (
    input  in_valid, pixel_flat, kernel_flat,
    output in_ready, data_rdy, data_out, sat
  );
endinterface

// File: rtl/conv_engine.sv
// Sequential KxK convolution: one multiply-accumulate per tap, then shift/clamp to OUT_W.
// Optional macro CONV_ROUND_EN: round half up before the right shift (when SHIFT > 0).
//
// state | meaning
// IDLE  | waiting for a window, in_ready follows enable
// MAC   | one tap multiplied and accumulated per enabled edge
// NORM  | shift, clamp and publish the result
module conv_engine #(
  parameter int PIX_W = 8,
  parameter int KER_W = 9,
  parameter int K     = 3,
  parameter int SHIFT = 0,
  parameter int OUT_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  conv_engine_if.slave  bus,
  output logic          busy
);
  localparam int TAPS   = K * K;
  localparam int CNT_W  = $clog2(TAPS);
  localparam int ACC_W  = PIX_W + KER_W + $clog2(TAPS) + 1;
  localparam int PROD_W = PIX_W + KER_W + 1;
  localparam int SUM_W  = ACC_W + 1;

`ifdef CONV_ROUND_EN
  localparam int RND_I = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 0;
`else
  localparam int RND_I = 0;
`endif
  localparam logic signed [SUM_W-1:0] RND     = SUM_W'(RND_I);
  localparam logic signed [SUM_W-1:0] MAX_OUT = SUM_W'((64'd1 << OUT_W) - 64'd1);

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, NORM = 2'd2} state_t;

  state_t                    state, state_nxt;
  logic [TAPS*PIX_W-1:0]     pix_r;
  logic [TAPS*KER_W-1:0]     ker_r;
  logic [CNT_W-1:0]          tap;
  logic signed [ACC_W-1:0]   acc;
  logic [PIX_W-1:0]          pix_sel;
  logic signed [KER_W-1:0]   ker_sel;
  logic signed [PROD_W-1:0]  prod;
  logic signed [SUM_W-1:0]   sum_rnd, sum_sh;
  logic [OUT_W-1:0]          clamp_val;
  logic                      clamp_sat;
  logic                      last_tap;
  logic [OUT_W-1:0]          data_out_r;
  logic                      sat_r;
  logic                      data_rdy_r;

  assign last_tap = (tap == CNT_W'(TAPS - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (enable) begin
      unique case (state)
        IDLE:    if (bus.in_valid) state_nxt = MAC;
        MAC:     if (last_tap)     state_nxt = NORM;
        NORM:                      state_nxt = IDLE;
        default:                   state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready = enable && (state == IDLE);
    busy         = (state != IDLE);
  end

  // Single shared multiplier: the pixel is unsigned, so it gets a zero sign bit.
  always_comb begin
    pix_sel = pix_r[tap*PIX_W +: PIX_W];
    ker_sel = ker_r[tap*KER_W +: KER_W];
    prod    = PROD_W'($signed({1'b0, pix_sel})) * PROD_W'(ker_sel);
  end

  always_comb begin
    sum_rnd   = SUM_W'(acc) + RND;
    sum_sh    = sum_rnd >>> SHIFT;
    clamp_val = sum_sh[OUT_W-1:0];
    clamp_sat = 1'b0;
    if (sum_sh < 0) begin
      clamp_val = '0;
      clamp_sat = 1'b1;
    end else if (sum_sh > MAX_OUT) begin
      clamp_val = '1;
      clamp_sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_r      <= '0;
      ker_r      <= '0;
      acc        <= '0;
      tap        <= '0;
      data_out_r <= '0;
      sat_r      <= 1'b0;
      data_rdy_r <= 1'b0;
    end else if (enable) begin
      data_rdy_r <= 1'b0;
      unique case (state)
        IDLE: if (bus.in_valid) begin
          pix_r <= bus.pixel_flat;
          ker_r <= bus.kernel_flat;
          acc   <= '0;
          tap   <= '0;
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          if (!last_tap) tap <= tap + 1'b1;
        end
        NORM: begin
          data_out_r <= clamp_val;
          sat_r      <= clamp_sat;
          data_rdy_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.data_out = data_out_r;
  assign bus.sat      = sat_r;
  assign bus.data_rdy = data_rdy_r;
endmodule

// File: tb/tb_conv_engine.sv
// Bench for conv_engine: two instances (SHIFT=0 and SHIFT=3) driven in lockstep and
// compared against a plain-arithmetic convolution model.
module tb_conv_engine;
  localparam int PIX_W = 8;
  localparam int KER_W = 9;
  localparam int K     = 3;
  localparam int OUT_W = 8;
  localparam int TAPS  = K * K;
`ifdef CONV_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic clk;
  logic reset;
  logic enable;
  logic busy0, busy3;

  int errors = 0;
  int checks = 0;
  int cur_px [TAPS];
  int cur_kw [TAPS];
  int exp0_q[$], sat0_q[$], exp3_q[$], sat3_q[$];

  conv_engine_if #(.PIX_W(PIX_W), .KER_W(KER_W), .K(K), .OUT_W(OUT_W)) d0 ();
  conv_engine_if #(.PIX_W(PIX_W), .KER_W(KER_W), .K(K), .OUT_W(OUT_W)) d3 ();

  conv_engine #(.PIX_W(PIX_W), .KER_W(KER_W), .K(K), .SHIFT(0), .OUT_W(OUT_W)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .bus(d0), .busy(busy0));
  conv_engine #(.PIX_W(PIX_W), .KER_W(KER_W), .K(K), .SHIFT(3), .OUT_W(OUT_W)) u3 (
    .clk(clk), .reset(reset), .enable(enable), .bus(d3), .busy(busy3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    for (int i = 0; i < TAPS; i++) begin
      d0.pixel_flat[i*PIX_W +: PIX_W]  = PIX_W'(cur_px[i]);
      d3.pixel_flat[i*PIX_W +: PIX_W]  = PIX_W'(cur_px[i]);
      d0.kernel_flat[i*KER_W +: KER_W] = KER_W'(cur_kw[i]);
      d3.kernel_flat[i*KER_W +: KER_W] = KER_W'(cur_kw[i]);
    end
  endtask

  task automatic set_valid(input logic v);
    d0.in_valid = v;
    d3.in_valid = v;
  endtask

  task automatic fill(input int p, input int w);
    for (int i = 0; i < TAPS; i++) begin
      cur_px[i] = p;
      cur_kw[i] = w;
    end
  endtask

  task automatic rnd_win();
    for (int i = 0; i < TAPS; i++) begin
      cur_px[i] = int'($urandom_range(0, 255));
      cur_kw[i] = int'($urandom_range(0, 511)) - 256;
    end
  endtask

  // Reference: exact dot product, optional half-up rounding, floor shift, clamp.
  task automatic model(input int sh, output int o, output int s);
    int sum;
    sum = 0;
    for (int i = 0; i < TAPS; i++) sum += cur_px[i] * cur_kw[i];
    if (ROUND && sh > 0) sum += (1 << (sh - 1));
    sum = sum >>> sh;
    if (sum < 0)                     begin o = 0;                s = 1; end
    else if (sum > (1 << OUT_W) - 1) begin o = (1 << OUT_W) - 1; s = 1; end
    else                             begin o = sum;              s = 0; end
  endtask

  task automatic wait_rdy(inout int n);
    do begin
      tick();
      n++;
    end while (!d0.data_rdy && n < 60);
  endtask

  task automatic run_window(input string tag);
    int o0, s0, o3, s3, lat;
    model(0, o0, s0);
    model(3, o3, s3);
    apply();
    set_valid(1'b1);
    chk({tag, "_in_ready"}, d0.in_ready, 1);
    tick();
    set_valid(1'b0);
    chk({tag, "_busy"}, busy0, 1);
    rnd_win();
    apply();
    lat = 0;
    wait_rdy(lat);
    chk({tag, "_latency"}, lat, TAPS + 1);
    chk({tag, "_rdy3"}, d3.data_rdy, 1);
    chk({tag, "_out0"}, d0.data_out, o0);
    chk({tag, "_sat0"}, d0.sat, s0);
    chk({tag, "_out3"}, d3.data_out, o3);
    chk({tag, "_sat3"}, d3.sat, s3);
    tick();
    chk({tag, "_rdy_drop"}, d0.data_rdy, 0);
  endtask

  initial begin
    int o0, s0, o3, s3, n, pulses, got;
    reset  = 1'b1;
    enable = 1'b1;
    set_valid(1'b0);
    fill(0, 0);
    apply();
    tick();
    tick();
    chk("rst_busy", busy0, 0);
    chk("rst_rdy", d0.data_rdy, 0);
    chk("rst_out", d0.data_out, 0);
    chk("rst_sat", d0.sat, 0);
    reset = 1'b0;
    tick();
    chk("rst_in_ready", d0.in_ready, 1);

    fill(0, 0);
    run_window("zeros");
    chk("zeros_const", d0.data_out, 0);

    cur_px = '{1, 1, 1, 0, 1, 0, 1, 1, 0};
    cur_kw = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
    run_window("sharpen");
    chk("sharpen_const", d0.data_out, 3);
    chk("sharpen_sat_const", d0.sat, 0);

    fill(255, 1);
    run_window("sat_hi");
    chk("sat_hi_const", d0.data_out, 255);
    chk("sat_hi_flag_const", d0.sat, 1);

    fill(10, -1);
    run_window("sat_lo");
    chk("sat_lo_const", d0.data_out, 0);
    chk("sat_lo_flag_const", d0.sat, 1);

    fill(7, 1);
    run_window("shift3");
    chk("shift3_const", d3.data_out, ROUND ? 8 : 7);

    fill(255, -256);
    run_window("min_kernel");
    fill(255, 255);
    run_window("max_kernel");

    for (int r = 0; r < 8; r++) begin
      rnd_win();
      run_window($sformatf("rand%0d", r));
    end

    // Enable low for four cycles in the middle of MAC.
    rnd_win();
    model(0, o0, s0);
    model(3, o3, s3);
    apply();
    set_valid(1'b1);
    tick();
    set_valid(1'b0);
    repeat (3) tick();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_in_ready", d0.in_ready, 0);
      chk("stall_busy", busy0, 1);
    end
    enable = 1'b1;
    n = 7;
    wait_rdy(n);
    chk("stall_latency", n, TAPS + 1 + 4);
    chk("stall_out0", d0.data_out, o0);
    chk("stall_out3", d3.data_out, o3);
    chk("stall_sat0", d0.sat, s0);
    enable = 1'b0;
    tick();
    chk("hold_rdy", d0.data_rdy, 1);
    chk("hold_out", d0.data_out, o0);
    enable = 1'b1;
    tick();
    chk("hold_rdy_drop", d0.data_rdy, 0);

    // Reset at tap 5 aborts the window.
    rnd_win();
    apply();
    set_valid(1'b1);
    tick();
    set_valid(1'b0);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", busy0, 0);
    chk("abort_busy3", busy3, 0);
    chk("abort_in_ready", d0.in_ready, 1);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (d0.data_rdy || d3.data_rdy) pulses++;
    end
    chk("abort_no_rdy", pulses, 0);

    // Reset wins over a simultaneous in_valid.
    set_valid(1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_valid(1'b0);
    chk("rst_prio_busy", busy0, 0);
    tick();
    chk("rst_prio_idle", busy0, 0);

    // Back-to-back windows with in_valid held high and inputs changing every busy cycle.
    rnd_win();
    apply();
    set_valid(1'b1);
    got = 0;
    for (int c = 0; c < 80 && got < 4; c++) begin
      if (d0.data_rdy) begin
        chk("stream_in_ready_with_rdy", d0.in_ready, 1);
        if (exp0_q.size() > 0) begin
          chk("stream_out0", d0.data_out, exp0_q.pop_front());
          chk("stream_sat0", d0.sat, sat0_q.pop_front());
          chk("stream_out3", d3.data_out, exp3_q.pop_front());
          chk("stream_sat3", d3.sat, sat3_q.pop_front());
        end
        got++;
      end
      if (d0.in_ready) begin
        model(0, o0, s0);
        model(3, o3, s3);
        exp0_q.push_back(o0);
        sat0_q.push_back(s0);
        exp3_q.push_back(o3);
        sat3_q.push_back(s3);
      end else begin
        rnd_win();
        apply();
      end
      tick();
    end
    set_valid(1'b0);
    chk("stream_results", got, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
